// File: rtl/id_issue_ctrl.sv
// Decode-stage issue controller: 2-entry instruction buffer, immediate-format
// classification of the head entry, single-cycle load-use bubble and flush.
module id_issue_ctrl #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [2:0]  imm_type,
  output logic [24:0] imm_in,
  output logic        illegal,
  output logic [15:0] bubble_cnt
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [2:0] RTYPE = 3'd0, ITYPE = 3'd1, STYPE = 3'd2,
                         BTYPE = 3'd3, UTYPE = 3'd4, JTYPE = 3'd5;
  localparam logic [6:0] OP_OP   = 7'b0110011, OP_IMM  = 7'b0010011,
                         OP_LOAD = 7'b0000011, OP_JALR = 7'b1100111,
                         OP_ST   = 7'b0100011, OP_BR   = 7'b1100011,
                         OP_LUI  = 7'b0110111, OP_AUI  = 7'b0010111,
                         OP_JAL  = 7'b1101111;

  typedef enum logic {ISSUE, BUBBLE} state_t;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  entry_t        ent [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  state_t        state, state_nxt;
  entry_t        head;
  logic          push, pop, nxt_present, load_use;
  logic [31:0]   nxt_inst;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [2:0] fmt_of(input logic [6:0] op);
    case (op)
      OP_IMM, OP_LOAD, OP_JALR: fmt_of = ITYPE;
      OP_ST:                    fmt_of = STYPE;
      OP_BR:                    fmt_of = BTYPE;
      OP_LUI, OP_AUI:           fmt_of = UTYPE;
      OP_JAL:                   fmt_of = JTYPE;
      default:                  fmt_of = RTYPE;
    endcase
  endfunction

  function automatic logic known_op(input logic [6:0] op);
    return op inside {OP_OP, OP_IMM, OP_LOAD, OP_JALR, OP_ST, OP_BR, OP_LUI, OP_AUI, OP_JAL};
  endfunction

  function automatic logic reads_reg(input logic [31:0] i, input logic [4:0] r);
    logic [2:0] f;
    logic       u1, u2;
    f  = fmt_of(i[6:0]);
    u1 = !(f inside {UTYPE, JTYPE});
    u2 = f inside {RTYPE, STYPE, BTYPE};
    return (u1 && i[19:15] == r) || (u2 && i[24:20] == r);
  endfunction

  assign head      = ent[rd_ptr];
  assign in_ready  = count < CW'(DEPTH);
  assign out_valid = (state == ISSUE) && (count != '0) && !flush;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;
  assign out_inst  = head.inst;
  assign out_pc    = head.pc;
  assign imm_in    = head.inst[31:7];
  assign imm_type  = fmt_of(head.inst[6:0]);
  assign illegal   = (count != '0) && !known_op(head.inst[6:0]);

  // The hazard is resolved one edge early: when a load pops, look at the entry
  // that becomes head next so the only lost cycle is the BUBBLE cycle itself.
  always_comb begin
    nxt_present = 1'b0;
    nxt_inst    = in_inst;
    if (count > CW'(1)) begin
      nxt_present = 1'b1;
      nxt_inst    = ent[inc(rd_ptr)].inst;
    end else if (count == CW'(1)) begin
      nxt_present = push;
    end
  end

  assign load_use = pop && (head.inst[6:0] == OP_LOAD) && (head.inst[11:7] != 5'd0) &&
                    nxt_present && reads_reg(nxt_inst, head.inst[11:7]);

  always_comb begin
    state_nxt = state;
    case (state)
      ISSUE:   if (load_use) state_nxt = BUBBLE;
      BUBBLE:  state_nxt = ISSUE;
      default: state_nxt = ISSUE;
    endcase
    if (flush) state_nxt = ISSUE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ISSUE;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      bubble_cnt <= '0;
      for (int k = 0; k < DEPTH; k++) ent[k] <= '0;
    end else begin
      state <= state_nxt;
      if (state == BUBBLE && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          ent[wr_ptr] <= '{inst: in_inst, pc: in_pc};
          wr_ptr      <= inc(wr_ptr);
        end
        if (pop) rd_ptr <= inc(rd_ptr);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_id_issue_ctrl.sv
// Self-checking bench for id_issue_ctrl: directed scenarios plus randomized
// traffic compared against a queue-based issue model.
module tb_id_issue_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0] in_inst = '0, in_pc = '0;
  logic        in_ready, out_valid, illegal;
  logic [31:0] out_inst, out_pc;
  logic [2:0]  imm_type;
  logic [24:0] imm_in;
  logic [15:0] bubble_cnt;

  int checks = 0, failures = 0;

  id_issue_ctrl #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .imm_type(imm_type), .imm_in(imm_in), .illegal(illegal), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] LW5  = 32'h0000A283, ADD6 = 32'h00228333;
  localparam logic [31:0] LW0  = 32'h0000A003, ADD0 = 32'h00000333;
  localparam logic [31:0] IA   = 32'h00100093, IB   = 32'h00200113, IC = 32'h00300193;
  localparam logic [31:0] FMT [5] = '{32'h00112223, 32'h00208463, 32'h123450B7, 32'h008000EF, 32'h0000007F};
  localparam int          FTY [5] = '{2, 3, 4, 5, 0};
  localparam logic [6:0]  OPS [11] = '{7'h33, 7'h13, 7'h03, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h5B};

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } mentry_t;
  mentry_t     mq[$];
  bit          m_pl;     // the previous cycle issued a load
  logic [4:0]  m_prd;
  int          m_bcnt;

  function automatic int m_type(input logic [31:0] i);
    case (i[6:0])
      7'h13, 7'h03, 7'h67: return 1;
      7'h23:               return 2;
      7'h63:               return 3;
      7'h37, 7'h17:        return 4;
      7'h6F:               return 5;
      default:             return 0;
    endcase
  endfunction

  function automatic bit m_illegal(input logic [31:0] i);
    return !(i[6:0] inside {7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F});
  endfunction

  function automatic bit m_reads(input logic [31:0] i, input logic [4:0] r);
    int t;
    t = m_type(i);
    return ((t != 4 && t != 5) && i[19:15] == r) || ((t == 0 || t == 2 || t == 3) && i[24:20] == r);
  endfunction

  function automatic bit m_bub();
    return m_pl && m_prd != 5'd0 && mq.size() > 0 && m_reads(mq[0].inst, m_prd);
  endfunction

  function automatic bit m_ov();
    return mq.size() > 0 && !m_bub() && !flush;
  endfunction

  task automatic model_step();
    bit bub, pop, push;
    mentry_t e;
    if (rst) begin
      mq.delete(); m_pl = 0; m_prd = '0; m_bcnt = 0;
    end else begin
      bub  = m_bub();
      pop  = m_ov() && out_ready;
      push = in_valid && mq.size() < 2 && !flush;
      if (bub && m_bcnt < 65535) m_bcnt++;
      if (flush) begin
        mq.delete(); m_pl = 0;
      end else begin
        m_pl = 0;
        if (pop) begin
          e = mq.pop_front();
          m_pl = (e.inst[6:0] == 7'h03);
          m_prd = e.inst[11:7];
        end
        if (push) mq.push_back('{in_inst, in_pc});
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    in_valid = 0; flush = 0;
    @(negedge clk);
    cyc();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1; in_valid = 0; flush = 0; out_ready = 0;
    cyc(); cyc();
    rst = 0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (out_inst !== 32'h0 || out_pc !== 32'h0) begin failures++; $display("FAIL reset_inst_pc got=%h/%h exp=0/0", out_inst, out_pc); end
    checks++; if (imm_type !== 3'd0 || illegal !== 1'b0) begin failures++; $display("FAIL reset_type_illegal got=%0d/%0b exp=0/0", imm_type, illegal); end
    checks++; if (bubble_cnt !== 16'd0) begin failures++; $display("FAIL reset_bubble_cnt got=%0d exp=0", bubble_cnt); end
    cyc();
  endtask

  task automatic test_single();
    logic [31:0] w;
    w = 32'h00500093;
    out_ready = 1; in_valid = 1; in_inst = w; in_pc = 32'h100;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL single_in_ready got=%0b exp=1", in_ready); end
    cyc();
    in_valid = 0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || imm_type !== 3'd1) begin failures++; $display("FAIL single_issue got=%0b/%0d exp=1/1", out_valid, imm_type); end
    checks++; if (imm_in !== w[31:7] || out_pc !== 32'h100) begin failures++; $display("FAIL single_imm_pc got=%h/%h exp=%h/100", imm_in, out_pc, w[31:7]); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL single_in_ready2 got=%0b exp=1", in_ready); end
    cyc();
    in_valid = 0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_drained got=%0b exp=0", out_valid); end
    cyc();
  endtask

  task automatic test_formats();
    out_ready = 1;
    for (int k = 0; k <= 5; k++) begin
      in_valid = (k < 5);
      if (k < 5) begin in_inst = FMT[k]; in_pc = 32'h200 + 32'(4 * k); end
      @(negedge clk);
      if (k > 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_inst !== FMT[k-1] || imm_type !== 3'(FTY[k-1]) || illegal !== (k == 5))
          begin failures++; $display("FAIL format_%0d got=v%0b i%h t%0d il%0b exp=v1 i%h t%0d il%0b", k-1, out_valid, out_inst, imm_type, illegal, FMT[k-1], FTY[k-1], (k == 5)); end
      end
      cyc();
    end
    idle();
  endtask

  task automatic test_load_use();
    logic [31:0] seq [4];
    bit          ev  [7];
    seq = '{LW5, ADD6, LW0, ADD0};
    ev  = '{0, 1, 0, 1, 0, 1, 1};
    out_ready = 1;
    for (int k = 0; k < 7; k++) begin
      in_valid = (k == 0 || k == 1 || k == 4 || k == 5);
      in_inst  = (k < 2) ? seq[k] : (k >= 4 && k < 6) ? seq[k-2] : 32'h0;
      in_pc    = 32'h300 + 32'(4 * k);
      @(negedge clk);
      checks++; if (out_valid !== ev[k]) begin failures++; $display("FAIL loaduse_valid_c%0d got=%0b exp=%0b", k, out_valid, ev[k]); end
      if (k == 2) begin checks++; if (bubble_cnt !== 16'd0) begin failures++; $display("FAIL loaduse_cnt_before got=%0d exp=0", bubble_cnt); end end
      if (k == 3) begin checks++; if (out_inst !== ADD6 || bubble_cnt !== 16'd1) begin failures++; $display("FAIL loaduse_after got=%h/%0d exp=%h/1", out_inst, bubble_cnt, ADD6); end end
      if (k == 6) begin checks++; if (out_inst !== ADD0 || bubble_cnt !== 16'd1) begin failures++; $display("FAIL loaduse_x0 got=%h/%0d exp=%h/1", out_inst, bubble_cnt, ADD0); end end
      cyc();
    end
    idle();
  endtask

  task automatic test_backpressure();
    logic [31:0] pv [3];
    pv = '{IA, IB, IC};
    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1; in_inst = pv[k]; in_pc = 32'h400 + 32'(4 * k);
      @(negedge clk);
      checks++; if (in_ready !== (k < 2)) begin failures++; $display("FAIL bp_in_ready_%0d got=%0b exp=%0b", k, in_ready, (k < 2)); end
      if (k > 0) begin checks++; if (out_valid !== 1'b1 || out_inst !== IA || out_pc !== 32'h400) begin failures++; $display("FAIL bp_hold_%0d got=%0b/%h exp=1/%h", k, out_valid, out_inst, IA); end end
      cyc();
    end
    in_valid = 0; out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k < 2) begin checks++; if (out_valid !== 1'b1 || out_inst !== pv[k]) begin failures++; $display("FAIL bp_drain_%0d got=%0b/%h exp=1/%h", k, out_valid, out_inst, pv[k]); end end
      else begin checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%0b exp=0", out_valid); end end
      cyc();
    end
  endtask

  task automatic test_flush();
    out_ready = 0;
    in_valid = 1; in_inst = IA; @(negedge clk); cyc();
    in_valid = 1; in_inst = IB; @(negedge clk); cyc();
    flush = 1; in_valid = 1; in_inst = IC;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_forced got=%0b exp=0", out_valid); end
    cyc();
    flush = 0; in_valid = 0; out_ready = 1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL flush_empty got=%0b/%0b exp=0/1", out_valid, in_ready); end
    cyc();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_lost got=%0b exp=0", out_valid); end
    cyc();
    // flush landing on the bubble cycle
    in_valid = 1; in_inst = LW5; @(negedge clk); cyc();
    in_valid = 1; in_inst = ADD6; @(negedge clk); cyc();
    flush = 1; in_valid = 1; in_inst = IA;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flushbub_valid got=%0b exp=0", out_valid); end
    cyc();
    flush = 0; in_valid = 1; in_inst = IB; in_pc = 32'h500;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flushbub_empty got=%0b exp=0", out_valid); end
    cyc();
    in_valid = 0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_inst !== IB || bubble_cnt !== 16'(m_bcnt)) begin failures++; $display("FAIL flushbub_resume got=%0b/%h/%0d exp=1/%h/%0d", out_valid, out_inst, bubble_cnt, IB, m_bcnt); end
    cyc();
  endtask

  function automatic logic [31:0] rnd_inst();
    logic [31:0] w;
    w = $urandom;
    w[6:0]   = OPS[$urandom_range(0, 10)];
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 99) < 3);
      in_inst   = rnd_inst();
      in_pc     = $urandom;
      @(negedge clk);
      checks++; if (out_valid !== m_ov()) begin failures++; $display("FAIL rnd_valid n=%0d got=%0b exp=%0b", n, out_valid, m_ov()); end
      checks++; if (in_ready !== (mq.size() < 2)) begin failures++; $display("FAIL rnd_in_ready n=%0d got=%0b exp=%0b", n, in_ready, (mq.size() < 2)); end
      checks++; if (bubble_cnt !== 16'(m_bcnt)) begin failures++; $display("FAIL rnd_bubble_cnt n=%0d got=%0d exp=%0d", n, bubble_cnt, m_bcnt); end
      if (mq.size() > 0) begin
        checks++;
        if (out_inst !== mq[0].inst || out_pc !== mq[0].pc || imm_in !== mq[0].inst[31:7] ||
            imm_type !== 3'(m_type(mq[0].inst)) || illegal !== m_illegal(mq[0].inst))
          begin failures++; $display("FAIL rnd_head n=%0d got=%h/%h t%0d il%0b exp=%h/%h t%0d il%0b", n, out_inst, out_pc, imm_type, illegal, mq[0].inst, mq[0].pc, m_type(mq[0].inst), m_illegal(mq[0].inst)); end
      end else begin
        checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL rnd_illegal_empty n=%0d got=%0b exp=0", n, illegal); end
      end
      cyc();
    end
    flush = 1; idle(); flush = 0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1;
    in_valid = 1; in_inst = LW5; @(negedge clk); cyc();
    in_valid = 1; in_inst = ADD6; @(negedge clk); cyc();
    rst = 1; flush = 1; in_valid = 1; in_inst = IC;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_in_bubble got=%0b exp=0", out_valid); end
    cyc();
    rst = 0; flush = 0; in_valid = 0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || bubble_cnt !== 16'd0) begin failures++; $display("FAIL rstmid_ctrl got=%0b/%0b/%0d exp=0/1/0", out_valid, in_ready, bubble_cnt); end
    checks++; if (out_inst !== 32'h0 || out_pc !== 32'h0 || imm_type !== 3'd0 || illegal !== 1'b0) begin failures++; $display("FAIL rstmid_data got=%h/%h/%0d/%0b exp=0/0/0/0", out_inst, out_pc, imm_type, illegal); end
    cyc();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_stays_empty got=%0b exp=0", out_valid); end
    cyc();
  endtask

  initial begin
    test_reset();
    test_single();
    test_formats();
    test_load_use();
    test_backpressure();
    test_flush();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
